// File: rtl/acq_seq_pkg.sv
// acq_seq_pkg: shared types and constants for the acquisition frame sequencer.
//   acq_state_e : 2-bit frame phase encoding (RST=0, IDLE=1, WRITE=2, READ=3)
//   CNT_W       : width of the shared phase/period cycle counter
//   FRAME_W     : width of the completed-frame counter
//   term_of()   : converts a phase length in cycles into its terminal count
package acq_seq_pkg;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned FRAME_W = 16;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } acq_state_e;

  // A phase of len cycles ends when the counter reaches len-1.
  function automatic logic [CNT_W-1:0] term_of(input int unsigned len);
    return CNT_W'(len - 32'd1);
  endfunction

endpackage

// File: rtl/acq_sequencer_cycle_timer.sv
// cycle_timer: free-running cycle counter shared by all sequencer phases.
//   clock, reset  : clock, asynchronous active-low reset
//   clear_i       : synchronous clear (wins over en_i)
//   en_i          : count enable
//   term_i        : terminal count for the current phase
//   at_term_c_o   : combinational, high while count >= term_i
module cycle_timer
  import acq_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             at_term_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ">=" rather than "==" so a deferred read strobe stays due while waiting.
  assign at_term_c_o = (cnt_q >= term_i);

endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: frame sequencer for the acquisition path
// (buffer reset -> idle -> capture -> periodic readout, repeating).
//   clock, reset : 50 MHz clock, asynchronous active-low reset
//   enable       : run frames back-to-back; low parks in IDLE after the frame
//   wr_full      : sample buffer full, ends capture early
//   rd_ready     : downstream can accept a read strobe
//   write_cmd    : capture enable level (lags WRITE by one cycle)
//   read_cmd     : one-cycle read strobe
//   reset_cmd    : buffer reset level (lags RST by one cycle)
//   busy         : sequencer not in IDLE
//   state        : current phase encoding
//   frame_cnt    : completed frames, wraps at 16 bits
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int unsigned IDLE_CYC    = 3_000_000,
  parameter int unsigned WRITE_LEN   = 1000,
  parameter int unsigned READ_PERIOD = 5000,
  parameter int unsigned READ_COUNT  = 1000,
  parameter int unsigned RESET_CYC   = 5_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               wr_full,
  input  logic               rd_ready,
  output logic               write_cmd,
  output logic               read_cmd,
  output logic               reset_cmd,
  output logic               busy,
  output logic [1:0]         state,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Zero-length phases cannot be sequenced.
  if (IDLE_CYC == 0 || WRITE_LEN == 0 || READ_PERIOD == 0 ||
      READ_COUNT == 0 || RESET_CYC == 0) begin : g_bad_param
    $error("acq_sequencer: phase length parameters must be non-zero");
  end

  acq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   rd_n_q, rd_n_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               write_cmd_q, read_cmd_q, reset_cmd_q, busy_q;
  logic [CNT_W-1:0]   term;
  logic               at_term, issue, idle_hold, timer_clr;

  // Terminal count of the shared timer for the current phase.
  always_comb begin
    term = term_of(RESET_CYC);
    case (state_q)
      ST_IDLE:  term = term_of(IDLE_CYC);
      ST_WRITE: term = term_of(WRITE_LEN);
      ST_READ:  term = term_of(READ_PERIOD);
      default:  term = term_of(RESET_CYC);
    endcase
  end

  // Timer restarts on every phase change, on every strobe, and while IDLE is disabled.
  assign timer_clr = (state_d != state_q) || issue || idle_hold;

  cycle_timer u_timer (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (timer_clr),
    .en_i        (1'b1),
    .term_i      (term),
    .at_term_c_o (at_term)
  );

  // Phase transitions, strobe issue and frame bookkeeping.
  always_comb begin
    state_d     = state_q;
    rd_n_d      = rd_n_q;
    frame_cnt_d = frame_cnt_q;
    issue       = 1'b0;
    idle_hold   = 1'b0;
    case (state_q)
      ST_RST: begin
        if (at_term) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!enable) begin
          idle_hold = 1'b1;
        end else if (at_term) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (at_term || wr_full) state_d = ST_READ;
      end
      ST_READ: begin
        if (at_term && rd_ready) begin
          issue  = 1'b1;
          rd_n_d = rd_n_q + CNT_W'(1);
          if (rd_n_q == term_of(READ_COUNT)) begin
            state_d     = ST_RST;
            rd_n_d      = '0;
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          end
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  // State and registered outputs; command outputs reflect the previous cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RST;
      rd_n_q      <= '0;
      frame_cnt_q <= '0;
      write_cmd_q <= 1'b0;
      read_cmd_q  <= 1'b0;
      reset_cmd_q <= 1'b1;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      rd_n_q      <= rd_n_d;
      frame_cnt_q <= frame_cnt_d;
      write_cmd_q <= (state_q == ST_WRITE);
      read_cmd_q  <= issue;
      reset_cmd_q <= (state_q == ST_RST);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign write_cmd = write_cmd_q;
  assign read_cmd  = read_cmd_q;
  assign reset_cmd = reset_cmd_q;
  assign busy      = busy_q;
  assign state     = state_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a phase-schedule reference model.
module tb_acq_sequencer;

  localparam int unsigned IDLE_CYC    = 10;
  localparam int unsigned WRITE_LEN   = 8;
  localparam int unsigned READ_PERIOD = 4;
  localparam int unsigned READ_COUNT  = 3;
  localparam int unsigned RESET_CYC   = 5;

  localparam int P_RST   = 0;
  localparam int P_IDLE  = 1;
  localparam int P_WRITE = 2;
  localparam int P_READ  = 3;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        wr_full;
  logic        rd_ready;
  logic        write_cmd;
  logic        read_cmd;
  logic        reset_cmd;
  logic        busy;
  logic [1:0]  state;
  logic [15:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  acq_sequencer #(
    .IDLE_CYC    (IDLE_CYC),
    .WRITE_LEN   (WRITE_LEN),
    .READ_PERIOD (READ_PERIOD),
    .READ_COUNT  (READ_COUNT),
    .RESET_CYC   (RESET_CYC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .wr_full   (wr_full),
    .rd_ready  (rd_ready),
    .write_cmd (write_cmd),
    .read_cmd  (read_cmd),
    .reset_cmd (reset_cmd),
    .busy      (busy),
    .state     (state),
    .frame_cnt (frame_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: phase, cycles left in the phase, cycles since last strobe.
  int          m_ph      = P_RST;
  int          m_left    = RESET_CYC;
  int          m_since   = 0;
  int          m_strobes = 0;
  logic [15:0] m_frames  = 16'd0;
  logic        e_write   = 1'b0;
  logic        e_read    = 1'b0;
  logic        e_reset   = 1'b1;
  logic        e_busy    = 1'b1;

  task automatic model_reset();
    m_ph = P_RST; m_left = RESET_CYC; m_since = 0; m_strobes = 0;
    m_frames = 16'd0;
    e_write = 1'b0; e_read = 1'b0; e_reset = 1'b1; e_busy = 1'b1;
  endtask

  task automatic model_step();
    int prev;
    bit strobe;
    prev   = m_ph;
    strobe = 1'b0;
    case (m_ph)
      P_RST: begin
        m_left--;
        if (m_left == 0) begin m_ph = P_IDLE; m_left = IDLE_CYC; end
      end
      P_IDLE: begin
        if (!enable) m_left = IDLE_CYC;
        else begin
          m_left--;
          if (m_left == 0) begin m_ph = P_WRITE; m_left = WRITE_LEN; end
        end
      end
      P_WRITE: begin
        m_left--;
        if (wr_full || m_left == 0) begin m_ph = P_READ; m_since = 0; m_strobes = 0; end
      end
      default: begin
        m_since++;
        if (m_since >= READ_PERIOD && rd_ready) begin
          strobe = 1'b1;
          m_since = 0;
          m_strobes++;
          if (m_strobes == READ_COUNT) begin
            m_ph = P_RST; m_left = RESET_CYC; m_frames++;
          end
        end
      end
    endcase
    e_write = (prev == P_WRITE);
    e_reset = (prev == P_RST);
    e_read  = strobe;
    e_busy  = (m_ph != P_IDLE);
  endtask

  function automatic logic [21:0] act_vec();
    return {state, busy, write_cmd, read_cmd, reset_cmd, frame_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: model advances on the edge, DUT compared at the following negedge.
  task automatic tick();
    logic [21:0] exp;
    @(posedge clock);
    if (!reset) model_reset();
    else model_step();
    @(negedge clock);
    exp = {2'(m_ph), e_busy, e_write, e_read, e_reset, m_frames};
    check("model_cycle {state,busy,wr,rd,rst,frame}", 32'(act_vec()), 32'(exp));
  endtask

  task automatic wait_state(input logic [1:0] s, input int maxc, input string name);
    int k;
    k = 0;
    while (state != s && k < maxc) begin
      tick();
      k++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  typedef struct {
    logic [2:0]  in_v;   // {enable, wr_full, rd_ready}
    int          ncyc;   // clock edges to apply before comparing
    logic [21:0] exp_v;  // {state, busy, write, read, reset, frame_cnt}
  } vec_t;

  vec_t vecs[17];

  initial begin
    int wc, rc;
    int rpos[$];

    // Power-up frame: RST 5, IDLE 10, WRITE 8, strobes at READ entry +4/+8/+12.
    vecs[0]  = '{3'b101, 0, {6'b00_1001, 16'd0}};
    vecs[1]  = '{3'b101, 4, {6'b00_1001, 16'd0}};
    vecs[2]  = '{3'b101, 1, {6'b01_0001, 16'd0}};
    vecs[3]  = '{3'b101, 1, {6'b01_0000, 16'd0}};
    vecs[4]  = '{3'b101, 8, {6'b01_0000, 16'd0}};
    vecs[5]  = '{3'b101, 1, {6'b10_1000, 16'd0}};
    vecs[6]  = '{3'b101, 1, {6'b10_1100, 16'd0}};
    vecs[7]  = '{3'b101, 6, {6'b10_1100, 16'd0}};
    vecs[8]  = '{3'b101, 1, {6'b11_1100, 16'd0}};
    vecs[9]  = '{3'b101, 1, {6'b11_1000, 16'd0}};
    vecs[10] = '{3'b101, 2, {6'b11_1000, 16'd0}};
    vecs[11] = '{3'b101, 1, {6'b11_1010, 16'd0}};
    vecs[12] = '{3'b101, 1, {6'b11_1000, 16'd0}};
    vecs[13] = '{3'b101, 3, {6'b11_1010, 16'd0}};
    vecs[14] = '{3'b101, 3, {6'b11_1000, 16'd0}};
    vecs[15] = '{3'b101, 1, {6'b00_1010, 16'd1}};
    vecs[16] = '{3'b101, 1, {6'b00_1001, 16'd1}};

    reset = 1'b0; enable = 1'b1; wr_full = 1'b0; rd_ready = 1'b1;
    tick();
    tick();
    #2 reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      {enable, wr_full, rd_ready} = vecs[i].in_v;
      repeat (vecs[i].ncyc) tick();
      check($sformatf("vec%0d {state,busy,wr,rd,rst,frame}", i), 32'(act_vec()), 32'(vecs[i].exp_v));
    end

    // Early full on the 3rd WRITE cycle, then 10 cycles of backpressure in READ.
    wait_state(2'd2, 40, "reach_write_1");
    wc = 0;
    tick(); wc += int'(write_cmd);
    tick(); wc += int'(write_cmd);
    wr_full = 1'b1;
    tick(); wc += int'(write_cmd);
    check("early_full_read_entry", 32'(state), 32'(P_READ));
    wr_full  = 1'b0;
    rd_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      wc += int'(write_cmd);
      if (read_cmd) rpos.push_back(k);
      if (k == 10) rd_ready = 1'b1;
    end
    check("early_full_write_high_cycles", 32'(wc), 32'd3);
    check("backpressure_strobe_count", 32'(rpos.size()), 32'd3);
    if (rpos.size() == 3) begin
      check("backpressure_strobe1_pos", 32'(rpos[0]), 32'd11);
      check("backpressure_strobe2_pos", 32'(rpos[1]), 32'd15);
      check("backpressure_strobe3_pos", 32'(rpos[2]), 32'd19);
    end

    // Enable dropped during WRITE: frame completes, then parks in IDLE.
    wait_state(2'd2, 60, "reach_write_2");
    enable = 1'b0;
    wait_state(2'd1, 80, "enable_drop_idle");
    check("enable_drop_busy", 32'(busy), 32'd0);
    check("enable_drop_frame_cnt", 32'(frame_cnt), 32'd3);
    repeat (30) tick();
    check("enable_drop_parked", 32'(state), 32'(P_IDLE));

    // Reset asserted mid-READ after the first strobe.
    enable = 1'b1;
    rc = 0;
    while (!read_cmd && rc < 100) begin
      tick();
      rc++;
    end
    check("first_strobe_seen", 32'(read_cmd), 32'd1);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", 32'(act_vec()), 32'({6'b00_1001, 16'd0}));
    model_reset();
    tick();
    #2 reset = 1'b1;
    rc = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (read_cmd) rc++;
      if (frame_cnt == 16'd1) break;
    end
    check("post_reset_strobes", 32'(rc), 32'd3);
    check("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);

    // Frame counter wrap from 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    m_frames = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    wait_state(2'd3, 60, "wrap_reach_read");
    wait_state(2'd0, 40, "wrap_reach_rst");
    check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    // Randomized traffic with occasional mid-cycle resets.
    for (int k = 0; k < 3000; k++) begin
      enable   = ($urandom_range(0, 9) != 0);
      wr_full  = ($urandom_range(0, 19) == 0);
      rd_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        tick();
        #2 reset = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
